logic_accumulator: RTL and testbench

Registered, parametrised bitwise logic unit: the sequential successor to the single-bit OR gate component. It computes one of six bitwise operations (OR, AND, XOR, NOR, NAND, XNOR) over BIT_WIDTH-bit operands. Two modes are supported: pairwise (Input_1 op Input_2) and accumulate (running result op Input_1). Results pass through a one-deep valid/ready output stage. The block sits between custom-component datapaths that need sticky flag collection, mask building or parity folding across cycles.

---
 rtl/logic_accum_pkg.sv | 35 +++
 rtl/logic_accumulator_if.sv | 30 +++
 rtl/logic_op_unit.sv | 28 ++
 rtl/logic_accumulator.sv | 82 ++++++++
 tb/tb_logic_accumulator.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_accum_pkg.sv
// Shared definitions for the registered bitwise logic accumulator:
// operation encodings and the op-select decode helper.
package logic_accum_pkg;

    localparam int unsigned OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_OR   = 3'b000;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 3'b001;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_WIDTH-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_WIDTH-1:0] OP_NAND = 3'b100;
    localparam logic [OP_WIDTH-1:0] OP_XNOR = 3'b101;

    typedef enum logic [OP_WIDTH-1:0] {
        OPC_OR   = 3'd0,
        OPC_AND  = 3'd1,
        OPC_XOR  = 3'd2,
        OPC_NOR  = 3'd3,
        OPC_NAND = 3'd4,
        OPC_XNOR = 3'd5
    } op_e;

    // Unused encodings 110/111 fall back to OR.
    function automatic op_e decode_op(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_AND:  return OPC_AND;
            OP_XOR:  return OPC_XOR;
            OP_NOR:  return OPC_NOR;
            OP_NAND: return OPC_NAND;
            OP_XNOR: return OPC_XNOR;
            default: return OPC_OR;
        endcase
    endfunction

endpackage

// File: rtl/logic_accumulator_if.sv
// Operand/result handshake bundle for logic_accumulator.
interface logic_accumulator_if
    import logic_accum_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned COUNT_WIDTH = 8
);
    logic [OP_WIDTH-1:0]    Op;
    logic                   Accumulate;
    logic                   Clear;
    logic [BIT_WIDTH-1:0]   Input_1;
    logic [BIT_WIDTH-1:0]   Input_2;
    logic                   In_valid;
    logic                   In_ready;
    logic [BIT_WIDTH-1:0]   Output;
    logic                   Out_valid;
    logic                   Out_ready;
    logic [COUNT_WIDTH-1:0] Count;
    logic                   Sat;

    modport master (
        output Op, Accumulate, Clear, Input_1, Input_2, In_valid, Out_ready,
        input  In_ready, Output, Out_valid, Count, Sat
    );

    modport slave (
        input  Op, Accumulate, Clear, Input_1, Input_2, In_valid, Out_ready,
        output In_ready, Output, Out_valid, Count, Sat
    );
endinterface

// File: rtl/logic_op_unit.sv
// Combinational BIT_WIDTH-wide bitwise operator selected by a 3-bit op code.
module logic_op_unit
    import logic_accum_pkg::*;
#(
    parameter int unsigned UUID      = 0,
    parameter string       NAME      = "",
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]  op,
    output logic [BIT_WIDTH-1:0] y
);

    always_comb begin
        y = a | b;
        case (decode_op(op))
            OPC_OR:   y = a | b;
            OPC_AND:  y = a & b;
            OPC_XOR:  y = a ^ b;
            OPC_NOR:  y = ~(a | b);
            OPC_NAND: y = ~(a & b);
            OPC_XNOR: y = ~(a ^ b);
            default:  y = a | b;
        endcase
    end

endmodule

// File: rtl/logic_accumulator.sv
// Registered bitwise logic unit with pairwise/accumulate modes, a one-deep
// valid/ready output stage and a saturating accepted-sample counter.
module logic_accumulator
    import logic_accum_pkg::*;
#(
    parameter int unsigned UUID        = 0,
    parameter string       NAME        = "",
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_accumulator_if.slave   bus
);

    localparam int unsigned OP_UNIT_UUID = UUID ^ 32'd1;

    logic [BIT_WIDTH-1:0]   result_q, result_d;
    logic                   out_valid_q, out_valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [BIT_WIDTH-1:0]   op_a_c, op_b_c, op_y_c;
    logic                   in_ready_c, accept_c, count_sat_c;

    assign in_ready_c  = !bus.Clear && (!out_valid_q || bus.Out_ready);
    assign accept_c    = bus.In_valid && in_ready_c;
    assign count_sat_c = &count_q;

    // Accumulate folds the held result as the left operand.
    assign op_a_c = bus.Accumulate ? result_q    : bus.Input_1;
    assign op_b_c = bus.Accumulate ? bus.Input_1 : bus.Input_2;

    logic_op_unit #(
        .UUID      (OP_UNIT_UUID),
        .NAME      (NAME),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_op_unit (
        .a  (op_a_c),
        .b  (op_b_c),
        .op (bus.Op),
        .y  (op_y_c)
    );

    // Next-state: Clear dominates, then accept, then output consumption.
    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        if (bus.Clear) begin
            result_d    = '0;
            out_valid_d = 1'b0;
            count_d     = '0;
        end else if (accept_c) begin
            result_d    = op_y_c;
            out_valid_d = 1'b1;
            if (!count_sat_c) begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end else if (out_valid_q && bus.Out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign bus.In_ready  = in_ready_c;
    assign bus.Output    = result_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.Count     = count_q;
    assign bus.Sat       = count_sat_c;

endmodule

// File: tb/tb_logic_accumulator.sv
// Directed self-checking bench for logic_accumulator (8/8 and 8/2 builds).
module tb_logic_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    logic_accumulator_if #(.BIT_WIDTH(8), .COUNT_WIDTH(8)) bus ();
    logic_accumulator_if #(.BIT_WIDTH(8), .COUNT_WIDTH(2)) bus_s ();

    logic_accumulator #(.UUID(5), .NAME("main"), .BIT_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic_accumulator #(.UUID(6), .NAME("sat"), .BIT_WIDTH(8), .COUNT_WIDTH(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Values while reset is held from time zero.
        n_checks++;
        if (bus.Output !== 8'h00 || bus.Out_valid !== 1'b0 || bus.Count !== 8'd0 || bus.Sat !== 1'b0)
            $display("FAIL reset_init: out=%h vld=%b cnt=%0d sat=%b, want 00/0/0/0",
                     bus.Output, bus.Out_valid, bus.Count, bus.Sat);
        else n_pass++;
        n_checks++;
        if (bus.In_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.In_ready);
        else n_pass++;
        rst = 1'b0;
        step();
        // Build some state, then hit reset mid-cycle.
        bus.Op = 3'b000; bus.Input_1 = 8'h11; bus.Input_2 = 8'h22; bus.In_valid = 1'b1;
        step();
        n_checks++;
        if (bus.Output !== 8'h33 || bus.Count !== 8'd1) $display("FAIL pre_reset: out=%h cnt=%0d want 33/1", bus.Output, bus.Count);
        else n_pass++;
        bus.Out_ready = 1'b0;
        bus.In_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.Output !== 8'h00 || bus.Out_valid !== 1'b0 || bus.Count !== 8'd0 || bus.In_ready !== 1'b1)
            $display("FAIL async_reset: out=%h vld=%b cnt=%0d rdy=%b, want 00/0/0/1",
                     bus.Output, bus.Out_valid, bus.Count, bus.In_ready);
        else n_pass++;
        bus.Out_ready = 1'b1;
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic test_pairwise();
        bus.Accumulate = 1'b0;
        bus.Op = 3'b000; bus.Input_1 = 8'hA0; bus.Input_2 = 8'h05; bus.In_valid = 1'b1;
        step();
        n_checks++;
        if (bus.Output !== 8'hA5 || bus.Out_valid !== 1'b1 || bus.Count !== 8'd1)
            $display("FAIL pair_or: out=%h vld=%b cnt=%0d want A5/1/1", bus.Output, bus.Out_valid, bus.Count);
        else n_pass++;
        bus.Op = 3'b100; bus.Input_1 = 8'hF0; bus.Input_2 = 8'h3C;
        step();
        n_checks++;
        if (bus.Output !== 8'hCF || bus.Count !== 8'd2)
            $display("FAIL pair_nand: out=%h cnt=%0d want CF/2", bus.Output, bus.Count);
        else n_pass++;
        bus.In_valid = 1'b0;
        step();
        n_checks++;
        if (bus.Out_valid !== 1'b0 || bus.Output !== 8'hCF)
            $display("FAIL consume: vld=%b out=%h want 0/CF", bus.Out_valid, bus.Output);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4] = '{3'b010, 3'b010, 3'b101, 3'b111};
        logic [7:0] ia  [4] = '{8'h0F, 8'hAA, 8'h12, 8'h30};
        logic [7:0] ib  [4] = '{8'hFF, 8'h55, 8'h12, 8'h03};
        logic [7:0] exp [4] = '{8'hF0, 8'hFF, 8'hFF, 8'h33};
        bus.Accumulate = 1'b0;
        bus.In_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.Op = ops[i]; bus.Input_1 = ia[i]; bus.Input_2 = ib[i];
            step();
            n_checks++;
            if (bus.Output !== exp[i] || bus.Out_valid !== 1'b1 || bus.Count !== 8'(3 + i))
                $display("FAIL b2b_%0d: out=%h vld=%b cnt=%0d want %h/1/%0d",
                         i, bus.Output, bus.Out_valid, bus.Count, exp[i], 3 + i);
            else n_pass++;
        end
        bus.In_valid = 1'b0;
        step();
    endtask

    task automatic test_accumulate();
        logic [7:0] seq [3] = '{8'h01, 8'h02, 8'h80};
        bus.Op = 3'b000; bus.Clear = 1'b1;
        step();
        bus.Clear = 1'b0;
        n_checks++;
        if (bus.Output !== 8'h00 || bus.Count !== 8'd0 || bus.Out_valid !== 1'b0)
            $display("FAIL acc_clear: out=%h cnt=%0d vld=%b want 00/0/0", bus.Output, bus.Count, bus.Out_valid);
        else n_pass++;
        bus.Accumulate = 1'b1; bus.In_valid = 1'b1; bus.Input_2 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bus.Input_1 = seq[i];
            step();
        end
        n_checks++;
        if (bus.Output !== 8'h83 || bus.Count !== 8'd3)
            $display("FAIL acc_or: out=%h cnt=%0d want 83/3", bus.Output, bus.Count);
        else n_pass++;
        bus.Op = 3'b010; bus.Input_1 = 8'hFF;
        step();
        n_checks++;
        if (bus.Output !== 8'h7C) $display("FAIL acc_xor1: out=%h want 7C", bus.Output);
        else n_pass++;
        step();
        n_checks++;
        if (bus.Output !== 8'h83 || bus.Count !== 8'd5)
            $display("FAIL acc_xor2: out=%h cnt=%0d want 83/5", bus.Output, bus.Count);
        else n_pass++;
        // NOR folds invert every step: 83 -> ~(83|0F)=70 -> ~(70|0F)=80.
        bus.Op = 3'b011; bus.Input_1 = 8'h0F;
        step();
        n_checks++;
        if (bus.Output !== 8'h70) $display("FAIL acc_nor1: out=%h want 70", bus.Output);
        else n_pass++;
        step();
        n_checks++;
        if (bus.Output !== 8'h80) $display("FAIL acc_nor2: out=%h want 80", bus.Output);
        else n_pass++;
        bus.In_valid = 1'b0; bus.Accumulate = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        bus.Op = 3'b001; bus.Input_1 = 8'h3C; bus.Input_2 = 8'h0F; bus.In_valid = 1'b1; bus.Out_ready = 1'b1;
        step();
        n_checks++;
        if (bus.Output !== 8'h0C || bus.Out_valid !== 1'b1 || bus.Count !== 8'd8)
            $display("FAIL bp_load: out=%h vld=%b cnt=%0d want 0C/1/8", bus.Output, bus.Out_valid, bus.Count);
        else n_pass++;
        bus.Out_ready = 1'b0; bus.Input_1 = 8'hFF; bus.Input_2 = 8'hF0;
        #1;
        n_checks++;
        if (bus.In_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", bus.In_ready);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.Output !== 8'h0C || bus.Count !== 8'd8 || bus.Out_valid !== 1'b1)
                $display("FAIL bp_hold_%0d: out=%h cnt=%0d vld=%b want 0C/8/1", i, bus.Output, bus.Count, bus.Out_valid);
            else n_pass++;
        end
        bus.Out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.In_ready !== 1'b1) $display("FAIL bp_ready_high: got %b want 1", bus.In_ready);
        else n_pass++;
        step();
        n_checks++;
        if (bus.Output !== 8'hF0 || bus.Count !== 8'd9 || bus.Out_valid !== 1'b1)
            $display("FAIL bp_release: out=%h cnt=%0d vld=%b want F0/9/1", bus.Output, bus.Count, bus.Out_valid);
        else n_pass++;
        bus.In_valid = 1'b0;
        step();
    endtask

    task automatic test_clear_collision();
        bus.Op = 3'b000; bus.Input_1 = 8'h0F; bus.Input_2 = 8'h00; bus.In_valid = 1'b1;
        step();
        bus.Clear = 1'b1;
        #1;
        n_checks++;
        if (bus.In_ready !== 1'b0) $display("FAIL clr_ready: got %b want 0", bus.In_ready);
        else n_pass++;
        step();
        bus.Clear = 1'b0; bus.In_valid = 1'b0;
        n_checks++;
        if (bus.Output !== 8'h00 || bus.Count !== 8'd0 || bus.Out_valid !== 1'b0)
            $display("FAIL clr_state: out=%h cnt=%0d vld=%b want 00/0/0", bus.Output, bus.Count, bus.Out_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_saturation();
        logic [7:0] seq  [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        logic [7:0] eout [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
        logic [1:0] ecnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       esat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus_s.Op = 3'b010; bus_s.Accumulate = 1'b1; bus_s.In_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_s.Input_1 = seq[i];
            step();
            n_checks++;
            if (bus_s.Output !== eout[i] || bus_s.Count !== ecnt[i] || bus_s.Sat !== esat[i])
                $display("FAIL sat_%0d: out=%h cnt=%0d sat=%b want %h/%0d/%b",
                         i, bus_s.Output, bus_s.Count, bus_s.Sat, eout[i], ecnt[i], esat[i]);
            else n_pass++;
        end
        bus_s.In_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.Op = 3'b000; bus.Accumulate = 1'b0; bus.Clear = 1'b0;
        bus.Input_1 = 8'h00; bus.Input_2 = 8'h00; bus.In_valid = 1'b0; bus.Out_ready = 1'b1;
        bus_s.Op = 3'b000; bus_s.Accumulate = 1'b0; bus_s.Clear = 1'b0;
        bus_s.Input_1 = 8'h00; bus_s.Input_2 = 8'h00; bus_s.In_valid = 1'b0; bus_s.Out_ready = 1'b1;
        #12;
        test_reset();
        test_pairwise();
        test_back_to_back();
        test_accumulate();
        test_backpressure();
        test_clear_collision();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
